// File: rtl/spu_result_drain_if.sv
// Global buffer read port and signed-byte output stream of the SPU result drain.
// The master side is the drain engine; the slave side is the buffer plus downstream consumer.
interface spu_result_drain_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  gbuf_cen;
    logic                  gbuf_wen;
    logic [ADDR_WIDTH-1:0] gbuf_addr;
    logic [DATA_WIDTH-1:0] gbuf_dout;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0]            out_data;
    logic                  out_last;

    modport master (
        output gbuf_cen, gbuf_wen, gbuf_addr, out_valid, out_data, out_last,
        input  gbuf_dout, out_ready
    );
    modport slave (
        input  gbuf_cen, gbuf_wen, gbuf_addr, out_valid, out_data, out_last,
        output gbuf_dout, out_ready
    );
endinterface

// File: rtl/spu_result_drain.sv
// Drains a y*x int8 result matrix from the global buffer, one word per read,
// and streams its elements little-endian over a valid/ready byte interface.
module spu_result_drain #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  core_clk,
    input  logic                  rst_n,
    input  logic                  drain_start,
    input  logic [ADDR_WIDTH-1:0] matrix_y_in,
    input  logic [ADDR_WIDTH-1:0] matrix_x_in,
    input  logic [ADDR_WIDTH-1:0] om_base_addr_in,
    output logic                  drain_busy,
    output logic                  drain_done,
    spu_result_drain_if.master    bus
);

    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, EMIT, DONE} state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [23:0]           r_n;
    logic [21:0]           r_wcnt;
    logic [21:0]           r_word_idx;
    logic [23:0]           r_elem;
    logic [1:0]            r_byte_idx;
    logic [DATA_WIDTH-1:0] r_word;

    logic [23:0] w_n;
    logic [24:0] w_n_round;
    logic [21:0] w_wcnt;
    logic        w_hs;
    logic        w_last;
    logic        w_more_words;

    assign w_n          = 24'(matrix_y_in) * 24'(matrix_x_in);
    assign w_n_round    = {1'b0, w_n} + 25'd3;
    assign w_wcnt       = w_n_round[23:2];
    assign w_hs         = (r_state == EMIT) && bus.out_ready;
    assign w_last       = (r_elem == r_n - 24'd1);
    assign w_more_words = (r_word_idx + 22'd1) < r_wcnt;

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (drain_start) w_next = (w_n == 24'd0) ? DONE : ISSUE;
            ISSUE:   w_next = CAPTURE;
            CAPTURE: w_next = EMIT;
            EMIT: begin
                // Word count bounds the walk as well, so a corrupt element count cannot run away.
                if (w_hs) begin
                    if (w_last)                  w_next = DONE;
                    else if (r_byte_idx == 2'd3) w_next = w_more_words ? ISSUE : DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base     <= '0;
            r_n        <= '0;
            r_wcnt     <= '0;
            r_word_idx <= '0;
            r_elem     <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
        end else begin
            case (r_state)
                IDLE: if (drain_start) begin
                    r_base     <= om_base_addr_in;
                    r_n        <= w_n;
                    r_wcnt     <= w_wcnt;
                    r_word_idx <= '0;
                    r_elem     <= '0;
                    r_byte_idx <= '0;
                end
                CAPTURE: begin
                    r_word     <= bus.gbuf_dout;
                    r_byte_idx <= '0;
                end
                EMIT: if (w_hs) begin
                    r_elem     <= r_elem + 24'd1;
                    r_byte_idx <= r_byte_idx + 2'd1;
                    if (r_byte_idx == 2'd3) r_word_idx <= r_word_idx + 22'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from state so a reset forces them idle immediately.
    assign bus.gbuf_cen  = (r_state != ISSUE);
    assign bus.gbuf_wen  = 1'b1;
    assign bus.gbuf_addr = (r_state == ISSUE) ? r_base + ADDR_WIDTH'(r_word_idx) : '0;
    assign bus.out_valid = (r_state == EMIT);
    assign bus.out_data  = (r_state == EMIT) ? r_word[{r_byte_idx, 3'b000} +: 8] : 8'd0;
    assign bus.out_last  = (r_state == EMIT) && w_last;
    assign drain_busy    = (r_state == ISSUE) || (r_state == CAPTURE) || (r_state == EMIT);
    assign drain_done    = (r_state == DONE);

endmodule
